// File: rtl/pipeline_pkg.sv
// Shared datapath widths, ALU opcodes and the ID/EX bundle layout used by the
// pipeline registers of the five-stage MIPS core.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 16;

    localparam logic [3:0] ALUOP_NOP = 4'h0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] read_data1;
        logic [DATA_W-1:0] read_data2;
        logic [DATA_W-1:0] sign_ext_imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  shamt;
        logic              uses_rs;
        logic              uses_rt;
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              reg_dst;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              branch;
    } id_ex_t;

    // A bubble is an invalid slot with every control bit cleared and a NOP ALU op.
    localparam id_ex_t BUBBLE = '{alu_op: ALUOP_NOP, default: '0};

endpackage

// File: rtl/id_ex_register_if.sv
// ID/EX stage boundary: decoded instruction in, registered copy and hazard
// status out, plus the freeze/squash controls from the pipeline controller.
interface id_ex_register_if;
    import pipeline_pkg::*;

    logic             stall;
    logic             flush;
    id_ex_t           id;
    id_ex_t           ex;
    logic             hazard_stall;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output stall, flush, id,
        input  ex, hazard_stall, bubble_count
    );

    modport slave (
        input  stall, flush, id,
        output ex, hazard_stall, bubble_count
    );

endinterface

// File: rtl/id_ex_register_load_use_detect.sv
// Combinational load-use hazard detection between the instruction in ID and
// a load sitting in EX.
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    output logic             hazard_stall
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs && (id_rs == ex_rt);
    assign rt_match = id_uses_rt && (id_rt == ex_rt);

    // $zero can never carry a loaded value, so a load into it is not a hazard.
    assign hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rt != '0)
                          && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush/stall/load-use bubble insertion and a
// saturating count of inserted bubbles.
module id_ex_register
    import pipeline_pkg::*;
(
    input logic              clk,
    input logic              rst,
    id_ex_register_if.slave  bus
);

    id_ex_t           ex_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             hazard;
    logic             insert_bubble;

    load_use_detect u_load_use_detect (
        .id_valid     (bus.id.valid),
        .id_rs        (bus.id.rs),
        .id_rt        (bus.id.rt),
        .id_uses_rs   (bus.id.uses_rs),
        .id_uses_rt   (bus.id.uses_rt),
        .ex_valid     (ex_q.valid),
        .ex_mem_read  (ex_q.mem_read),
        .ex_rt        (ex_q.rt),
        .hazard_stall (hazard)
    );

    // Flush beats stall; a load-use bubble only goes in when not frozen.
    assign insert_bubble = bus.flush || (!bus.stall && hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (insert_bubble) begin
            ex_q <= BUBBLE;
        end else if (!bus.stall) begin
            ex_q <= bus.id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (insert_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bus.ex           = ex_q;
    assign bus.hazard_stall = hazard;
    assign bus.bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized and directed self-checking bench for id_ex_register against a
// cycle-level reference model of the ID/EX stage.
module tb_id_ex_register;
    import pipeline_pkg::*;

    logic clk;
    logic rst;

    id_ex_register_if bus ();

    id_ex_register dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checkCount;
    int     passCount;
    id_ex_t modelEx;
    int     modelCnt;

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Load-use rule evaluated directly from the architectural description.
    function automatic logic modelHazard(input id_ex_t id, input id_ex_t ex);
        logic depends;
        depends = (id.uses_rs && id.rs == ex.rt) || (id.uses_rt && id.rt == ex.rt);
        return id.valid && ex.valid && ex.mem_read && (ex.rt != 0) && depends;
    endfunction

    function automatic id_ex_t randomId();
        id_ex_t s;
        s.valid        = ($urandom_range(0, 3) != 0);
        s.pc_plus4     = $urandom;
        s.read_data1   = $urandom;
        s.read_data2   = $urandom;
        s.sign_ext_imm = $urandom;
        s.rs           = REG_W'($urandom_range(0, 3));
        s.rt           = REG_W'($urandom_range(0, 3));
        s.rd           = REG_W'($urandom);
        s.shamt        = REG_W'($urandom);
        s.uses_rs      = 1'($urandom);
        s.uses_rt      = 1'($urandom);
        s.alu_op       = 4'($urandom);
        s.alu_src      = 1'($urandom);
        s.reg_dst      = 1'($urandom);
        s.mem_read     = 1'($urandom);
        s.mem_write    = 1'($urandom);
        s.mem_to_reg   = 1'($urandom);
        s.reg_write    = 1'($urandom);
        s.branch       = 1'($urandom);
        return s;
    endfunction

    // Drive one cycle's inputs, check the combinational hazard, clock, then
    // check the registered bundle and bubble counter against the model.
    task automatic applyStimulus(input id_ex_t id, input logic stall, input logic flush);
        logic hz;
        bus.id    = id;
        bus.stall = stall;
        bus.flush = flush;
        #1;
        hz = modelHazard(id, modelEx);
        checkOutput("hazard_stall", 256'(bus.hazard_stall), 256'(hz));
        @(posedge clk);
        if (flush || (!stall && hz)) begin
            modelEx  = '0;
            modelCnt = (modelCnt < 65535) ? modelCnt + 1 : 65535;
        end else if (!stall) begin
            modelEx = id;
        end
        #1;
        checkOutput("ex_bundle", 256'(bus.ex), 256'(modelEx));
        checkOutput("bubble_count", 256'(bus.bubble_count), 256'(modelCnt));
    endtask

    initial begin
        id_ex_t s;
        checkCount = 0;
        passCount  = 0;
        modelEx    = '0;
        modelCnt   = 0;
        bus.id     = '0;
        bus.stall  = 1'b0;
        bus.flush  = 1'b0;
        rst        = 1'b1;
        #1;
        checkOutput("reset_ex", 256'(bus.ex), 256'(0));
        checkOutput("reset_count", 256'(bus.bubble_count), 256'(0));
        checkOutput("reset_hazard", 256'(bus.hazard_stall), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal load with a negative immediate passed bit-exact
        s = '0;
        s.valid = 1'b1; s.sign_ext_imm = 32'hFFFF8000;
        s.read_data1 = 32'h12345678; s.reg_write = 1'b1;
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("load_imm", 256'(bus.ex.sign_ext_imm), 256'(32'hFFFF8000));
        checkOutput("load_rd1", 256'(bus.ex.read_data1), 256'(32'h12345678));
        checkOutput("load_regwrite", 256'(bus.ex.reg_write), 256'(1));

        // lw $8 into EX, then dependent add in ID -> exactly one bubble
        s = '0;
        s.valid = 1'b1; s.rt = 5'd8; s.mem_read = 1'b1; s.mem_to_reg = 1'b1;
        s.reg_write = 1'b1; s.alu_src = 1'b1; s.alu_op = 4'h2;
        applyStimulus(s, 1'b0, 1'b0);
        s = '0;
        s.valid = 1'b1; s.rs = 5'd8; s.uses_rs = 1'b1; s.rt = 5'd3;
        s.rd = 5'd4; s.reg_dst = 1'b1; s.reg_write = 1'b1; s.alu_op = 4'h2;
        bus.id = s;
        #1;
        checkOutput("loaduse_hazard", 256'(bus.hazard_stall), 256'(1));
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("loaduse_bubble", 256'(bus.ex), 256'(0));
        checkOutput("loaduse_count", 256'(bus.bubble_count), 256'(1));
        checkOutput("loaduse_drop", 256'(bus.hazard_stall), 256'(0));
        applyStimulus(s, 1'b0, 1'b0);
        checkOutput("loaduse_dep_loaded", 256'(bus.ex.rs), 256'(8));

        // Loads into $zero, and unused operands, never raise the hazard
        s = '0;
        s.valid = 1'b1; s.rt = 5'd0; s.mem_read = 1'b1;
        applyStimulus(s, 1'b0, 1'b0);
        s = '0;
        s.valid = 1'b1; s.rs = 5'd0; s.uses_rs = 1'b1;
        bus.id = s;
        #1;
        checkOutput("zero_reg_hazard", 256'(bus.hazard_stall), 256'(0));
        s = '0;
        s.valid = 1'b1; s.rt = 5'd9; s.mem_read = 1'b1;
        applyStimulus(s, 1'b0, 1'b0);
        s = '0;
        s.valid = 1'b1; s.rt = 5'd9; s.uses_rt = 1'b0;
        bus.id = s;
        #1;
        checkOutput("unused_rt_hazard", 256'(bus.hazard_stall), 256'(0));
        applyStimulus(s, 1'b0, 1'b0);

        // Three stalled cycles with changing inputs, then stall+flush together
        for (int i = 0; i < 3; i++) applyStimulus(randomId(), 1'b1, 1'b0);
        applyStimulus(randomId(), 1'b1, 1'b1);

        // Randomized traffic with occasional stall and flush
        for (int i = 0; i < 400; i++)
            applyStimulus(randomId(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));

        // Drive the bubble counter past its ceiling
        bus.flush = 1'b1;
        bus.stall = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        modelEx  = '0;
        modelCnt = (modelCnt + 65540 > 65535) ? 65535 : modelCnt + 65540;
        checkOutput("saturate_count", 256'(bus.bubble_count), 256'(16'hFFFF));
        applyStimulus(randomId(), 1'b0, 1'b1);

        // Asynchronous reset between edges
        s = randomId();
        s.valid = 1'b1; s.reg_write = 1'b1; s.mem_read = 1'b0;
        applyStimulus(s, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_regwrite", 256'(bus.ex.reg_write), 256'(0));
        checkOutput("async_count", 256'(bus.bubble_count), 256'(0));
        modelEx  = '0;
        modelCnt = 0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(randomId(), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
